mem_param: RTL and testbench

MEM_PARAM -- requirements
Module: mem_param

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rd_pipe.sv | 54 +++++
 rtl/mem_param.sv | 114 +++++++++++
 tb/tb_mem_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the mem_param single-port memory.
package mem_pkg;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StIdle = 1'b1
    } mem_state_e;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefDepth = 16;
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefRdLat = 1;

endpackage

// File: rtl/mem_rd_pipe.sv
// Response pipeline: RD_LAT stages of valid/err/data; the last data stage holds between responses.
module mem_rd_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] err_q, err_d;
    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [DATA_W-1:0] data_d [RD_LAT];

    always_comb begin
        valid_d    = valid_q;
        err_d      = err_q;
        data_d     = data_q;
        valid_d[0] = valid_i;
        err_d[0]   = err_i;
        data_d[0]  = valid_i ? data_i : data_q[0];
        // Data only advances alongside a valid so the output stage keeps its last value.
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign err_o   = err_q[RD_LAT-1];
    assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_param.sv
// Single-port byte-writable memory that zero-fills itself after reset, then serves
// one read or write per cycle with a RD_LAT-cycle registered response.
module mem_param
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned RD_LAT = DefRdLat
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                En,
    input  logic                W_en,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W/8-1:0] Be,
    input  logic [DATA_W-1:0]   Data_in,
    output logic [DATA_W-1:0]   Data_out,
    output logic                Valid_out,
    output logic                Err_out,
    output logic                Busy
);

    localparam int unsigned NumBytes = DATA_W / 8;

    mem_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                addr_ok;
    logic                last_init;
    logic                mem_we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [NumBytes-1:0] wr_be;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                rd_err;

    assign addr_ok   = 32'(Address) < DEPTH;
    assign last_init = 32'(init_cnt_q) == DEPTH - 1;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_we     = 1'b0;
        wr_addr    = Address;
        wr_be      = Be;
        wr_data    = Data_in;
        rd_valid   = 1'b0;
        rd_err     = 1'b0;
        unique case (state_q)
            StInit: begin
                // Requests are ignored here; the write port belongs to the clear sweep.
                mem_we     = 1'b1;
                wr_addr    = init_cnt_q;
                wr_be      = '1;
                wr_data    = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (last_init) begin
                    state_d    = StIdle;
                    init_cnt_d = '0;
                end
            end
            StIdle: begin
                if (En) begin
                    mem_we   = W_en & addr_ok;
                    rd_valid = ~W_en;
                    rd_err   = ~addr_ok;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // No reset on the array: contents are only defined once the clear sweep has run.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = addr_ok ? mem[Address] : '0;
    assign Busy    = (state_q == StInit);

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk),
        .rst_ni  (rst),
        .valid_i (rd_valid),
        .err_i   (rd_err),
        .data_i  (rd_data),
        .valid_o (Valid_out),
        .err_o   (Err_out),
        .data_o  (Data_out)
    );

endmodule

// File: tb/tb_mem_param.sv
// Directed bench for mem_param: a DEPTH=16/RD_LAT=1 and a DEPTH=12/RD_LAT=2 instance share stimulus.
module tb_mem_param;

    localparam int DEPTH_A = 16;
    localparam int LAT_A   = 1;
    localparam int DEPTH_B = 12;
    localparam int LAT_B   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        w_en = 1'b0;
    logic [3:0]  address = '0;
    logic [3:0]  be = '0;
    logic [31:0] data_in = '0;

    logic [31:0] dout_a, dout_b;
    logic        valid_a, valid_b, err_a, err_b, busy_a, busy_b;

    typedef struct {
        int          due;
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] model_a [DEPTH_A];
    logic [31:0] model_b [DEPTH_B];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int          na, nb;

    mem_param #(
        .DATA_W (32),
        .DEPTH  (DEPTH_A),
        .ADDR_W (4),
        .RD_LAT (LAT_A)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .En        (en),
        .W_en      (w_en),
        .Address   (address),
        .Be        (be),
        .Data_in   (data_in),
        .Data_out  (dout_a),
        .Valid_out (valid_a),
        .Err_out   (err_a),
        .Busy      (busy_a)
    );

    mem_param #(
        .DATA_W (32),
        .DEPTH  (DEPTH_B),
        .ADDR_W (4),
        .RD_LAT (LAT_B)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .En        (en),
        .W_en      (w_en),
        .Address   (address),
        .Be        (be),
        .Data_in   (data_in),
        .Data_out  (dout_b),
        .Valid_out (valid_b),
        .Err_out   (err_b),
        .Busy      (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Each monitor pops the response due this cycle, otherwise demands silence and a held Data_out.
    always @(negedge clk) begin
        exp_t it;
        if (mon_en) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                it = qa.pop_front();
                chk("a_valid", 32'(valid_a), 32'(it.v));
                chk("a_err", 32'(err_a), 32'(it.e));
                if (it.v) begin
                    chk("a_data", dout_a, it.d);
                    last_a = it.d;
                end else begin
                    chk("a_hold", dout_a, last_a);
                end
            end else begin
                chk("a_quiet_valid", 32'(valid_a), 32'd0);
                chk("a_quiet_err", 32'(err_a), 32'd0);
                chk("a_hold", dout_a, last_a);
            end
        end
    end

    always @(negedge clk) begin
        exp_t it;
        if (mon_en) begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                it = qb.pop_front();
                chk("b_valid", 32'(valid_b), 32'(it.v));
                chk("b_err", 32'(err_b), 32'(it.e));
                if (it.v) begin
                    chk("b_data", dout_b, it.d);
                    last_b = it.d;
                end else begin
                    chk("b_hold", dout_b, last_b);
                end
            end else begin
                chk("b_quiet_valid", 32'(valid_b), 32'd0);
                chk("b_quiet_err", 32'(err_b), 32'd0);
                chk("b_hold", dout_b, last_b);
            end
        end
    end

    task automatic expect_resp(input logic [3:0] a, input bit we, input bit use_exp,
                               input logic [31:0] exp_a);
        exp_t e;
        if (!we || int'(a) >= DEPTH_A) begin
            e.due = cyc + LAT_A;
            e.v   = !we;
            e.e   = int'(a) >= DEPTH_A;
            e.d   = '0;
            if (!we && !e.e) e.d = use_exp ? exp_a : model_a[a];
            qa.push_back(e);
        end
        if (!we || int'(a) >= DEPTH_B) begin
            e.due = cyc + LAT_B;
            e.v   = !we;
            e.e   = int'(a) >= DEPTH_B;
            e.d   = '0;
            if (!we && !e.e) e.d = model_b[a];
            qb.push_back(e);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; w_en = 1'b1; address = a; be = b; data_in = d;
        expect_resp(a, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            if (b[i] && int'(a) < DEPTH_A) model_a[a][8*i +: 8] = d[8*i +: 8];
            if (b[i] && int'(a) < DEPTH_B) model_b[a][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic rd(input logic [3:0] a);
        @(negedge clk);
        en = 1'b1; w_en = 1'b0; address = a;
        expect_resp(a, 1'b0, 1'b0, '0);
    endtask

    task automatic rd_exp(input logic [3:0] a, input logic [31:0] exp_a);
        @(negedge clk);
        en = 1'b1; w_en = 1'b0; address = a;
        expect_resp(a, 1'b0, 1'b1, exp_a);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0; w_en = 1'b0;
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < DEPTH_A; i++) model_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) model_b[i] = '0;
    endtask

    // Releases reset and counts Busy cycles; En stays high for the first ignore_cycles.
    task automatic count_busy(input int ignore_cycles, output int ca, output int cb);
        @(negedge clk);
        rst = 1'b1;
        ca = 0;
        cb = 0;
        for (int i = 0; i < 40; i++) begin
            en = (i < ignore_cycles);
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_models();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_busy_a", 32'(busy_a), 32'd1);
        chk("reset_busy_b", 32'(busy_b), 32'd1);
        chk("reset_dout_a", dout_a, 32'd0);
        chk("reset_dout_b", dout_b, 32'd0);

        // Writes of all-ones to address 2 during the sweep must be ignored.
        w_en = 1'b1; address = 4'd2; be = 4'hF; data_in = 32'hFFFF_FFFF;
        count_busy(8, na, nb);
        chk("busy_a_cycles", 32'(na), 32'd16);
        chk("busy_b_cycles", 32'(nb), 32'd12);

        for (int a = 0; a < 16; a++) rd_exp(4'(a), 32'h0000_0000);
        idle(3);

        wr(4'd3, 4'hF, 32'hDEAD_BEEF);
        rd_exp(4'd3, 32'hDEAD_BEEF);
        idle(2);
        wr(4'd3, 4'b0101, 32'h1122_3344);
        rd_exp(4'd3, 32'hDE22_BE44);
        wr(4'd3, 4'h0, 32'hFFFF_FFFF);
        rd_exp(4'd3, 32'hDE22_BE44);
        idle(2);

        wr(4'd1, 4'hF, 32'hA5A5_A5A5);
        wr(4'd13, 4'hF, 32'h1234_5678);
        rd_exp(4'd13, 32'h1234_5678);
        rd_exp(4'd1, 32'hA5A5_A5A5);
        idle(3);

        wr(4'd0, 4'hF, 32'h0101_0101);
        wr(4'd1, 4'hF, 32'h0202_0202);
        wr(4'd2, 4'hF, 32'h0303_0303);
        rd_exp(4'd0, 32'h0101_0101);
        rd_exp(4'd1, 32'h0202_0202);
        rd_exp(4'd2, 32'h0303_0303);
        idle(3);

        // Park both outputs at zero, then reset with a read still inside the RD_LAT=2 pipe.
        rd_exp(4'd4, 32'h0);
        idle(3);
        rd_exp(4'd4, 32'h0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        while (qa.size() > 0 && qa[qa.size()-1].due > cyc) void'(qa.pop_back());
        while (qb.size() > 0 && qb[qb.size()-1].due > cyc) void'(qb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_models();
        count_busy(0, na, nb);
        chk("rerun_busy_a_cycles", 32'(na), 32'd16);
        chk("rerun_busy_b_cycles", 32'(nb), 32'd12);

        rd_exp(4'd3, 32'h0);
        rd_exp(4'd1, 32'h0);
        rd_exp(4'd15, 32'h0);
        idle(4);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
